// File: rtl/voc_pkg.sv
// rtl/voc_pkg.sv - shared vocoder widths and FIFO entry sizing
package voc_pkg;

  localparam int VOC_WIDTH = 3;
  localparam int VOC_SIZE  = 8;

  // Each FIFO entry carries the burst-start tag above the sample bits.
  function automatic int entry_width(input int width);
    return width + 1;
  endfunction

  localparam int VOC_ENTRY_W = entry_width(VOC_WIDTH);

endpackage

// File: rtl/voc_out_fifo_if.sv
// rtl/voc_out_fifo_if.sv - sample input and sink handshake bundle for voc_out_fifo
interface voc_out_fifo_if #(
  parameter int WIDTH = 3
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_first, out_last
  );

endinterface

// File: rtl/voc_fifo_mem.sv
// rtl/voc_fifo_mem.sv - DEPTH x EW register array, sync write, async read
module voc_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int EW    = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/voc_out_fifo.sv
// rtl/voc_out_fifo.sv - FWFT output FIFO for vocoder playback with burst/frame tags
module voc_out_fifo
  import voc_pkg::*;
#(
  parameter int WIDTH  = VOC_WIDTH,
  parameter int DEPTH  = 16,
  parameter int FRAME  = VOC_SIZE,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  voc_out_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = entry_width(WIDTH);
  localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] frame_cnt;
  logic          prev_valid;
  logic [EW-1:0] rd_entry;
  logic          full, push, pop, drop, first_tag;

  assign full      = (level == LW'(DEPTH));
  assign pop       = bus.out_valid && bus.out_ready;
  // A full FIFO still takes a sample when the head leaves in the same cycle.
  assign push      = bus.in_valid && (!full || pop);
  assign drop      = bus.in_valid && full && !pop;
  assign first_tag = bus.in_valid && !prev_valid;

  voc_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_ptr  (wr_ptr),
    .wr_data ({first_tag, bus.in_data}),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_entry)
  );

  assign bus.out_valid = (level != '0);
  assign bus.out_data  = rd_entry[WIDTH-1:0];
  assign bus.out_first = bus.out_valid && rd_entry[WIDTH];
  assign bus.out_last  = bus.out_valid && (frame_cnt == FW'(FRAME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= bus.in_valid;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pop) begin
      frame_cnt <= bus.out_last ? '0 : frame_cnt + FW'(1);
    end
  end

  // Clear takes priority over a drop landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_voc_out_fifo.sv
// tb/tb_voc_out_fifo.sv - scoreboard bench for voc_out_fifo
module tb_voc_out_fifo;

  localparam int W  = 3;
  localparam int D  = 16;
  localparam int F  = 8;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [$clog2(D):0] level;
  logic              overflow;
  logic [DW-1:0]     drop_cnt;

  voc_out_fifo_if #(.WIDTH(W)) bus ();

  voc_out_fifo #(
    .WIDTH  (W),
    .DEPTH  (D),
    .FRAME  (F),
    .DROP_W (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q [$];
  int   m_count = 0;
  int   m_drops = 0;
  logic m_ovf   = 1'b0;
  logic m_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue-based FIFO occupancy and drop accounting.
  always @(negedge clk) begin
    logic pop, push, drop;
    if (!rst_n) begin
      exp_q.delete();
      m_count = 0;
      m_drops = 0;
      m_ovf   = 1'b0;
      m_prev  = 1'b0;
    end else begin
      check("level", int'(level), m_count);
      check("out_valid", int'(bus.out_valid), int'(m_count > 0));
      check("overflow", int'(overflow), int'(m_ovf));
      check("drop_cnt", int'(drop_cnt), m_drops);
      if (m_count == 0) begin
        check("first_empty", int'(bus.out_first), 0);
        check("last_empty", int'(bus.out_last), 0);
      end
      pop  = (m_count > 0) && bus.out_ready;
      push = bus.in_valid && ((m_count < D) || pop);
      drop = bus.in_valid && !push;
      if (push) exp_q.push_back({bus.in_valid && !m_prev, bus.in_data});
      m_count = m_count + int'(push) - int'(pop);
      if (clr_ovf) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end else if (drop) begin
        m_ovf   = 1'b1;
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end
      m_prev = bus.in_valid;
    end
  end

  int         pop_idx = 0;
  logic       hold_v  = 1'b0;
  logic [W-1:0] hold_d = '0;

  // Monitor: compares every accepted output against the scoreboard.
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      pop_idx = 0;
      hold_v  = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_data", int'(bus.out_data), int'(hold_d));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got output %0d with empty scoreboard", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(bus.out_data), int'(e[W-1:0]));
          check("out_first", int'(bus.out_first), int'(e[W]));
          check("out_last", int'(bus.out_last), int'((pop_idx % F) == F - 1));
          pop_idx++;
        end
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end
  end

  task automatic drive(input logic v, input int d, input logic r, input logic c);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = W'(d);
    bus.out_ready = r;
    clr_ovf       = c;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 0, 1'b1, 1'b0);
      if (level == 0) break;
    end
    check("drain_level", int'(level), 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_first", int'(bus.out_first), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_drop", int'(drop_cnt), 0);
    rst_n = 1'b1;

    // basic flow with one-cycle latency
    drive(1'b1, 5, 1'b1, 1'b0);
    drive(1'b1, 2, 1'b1, 1'b0);
    check("lat_data0", int'(bus.out_data), 5);
    check("lat_first0", int'(bus.out_first), 1);
    drive(1'b1, 7, 1'b1, 1'b0);
    check("lat_data1", int'(bus.out_data), 2);
    check("lat_first1", int'(bus.out_first), 0);
    drive(1'b0, 0, 1'b1, 1'b0);
    check("lat_data2", int'(bus.out_data), 7);
    drain();

    // fill past full
    for (int i = 0; i < 20; i++) drive(1'b1, i % 8, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    check("fill_level", int'(level), 16);
    check("fill_ovf", int'(overflow), 1);
    check("fill_drop", int'(drop_cnt), 4);
    drain();

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) drive(1'b1, i % 8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 7 - i, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    check("fullpp_level", int'(level), 16);
    check("fullpp_drop", int'(drop_cnt), 4);
    drain();

    // frame tagging from a fresh frame counter
    do_reset(1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) drive(1'b1, int'($urandom_range(0, 7)), 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);
      drive(1'b0, 0, 1'b1, 1'b0);
    end
    drain();

    // backpressure toggling
    for (int c = 0; c < 200; c++) drive(logic'($urandom_range(0, 1)), int'($urandom_range(0, 7)), logic'(c % 2), 1'b0);
    drain();

    // reset mid-burst
    for (int i = 0; i < 6; i++) drive(1'b1, i, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mid_level", int'(level), 6);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("async_level", int'(level), 0);
    check("async_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 3, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    check("post_rst_first", int'(bus.out_first), 1);
    check("post_rst_data", int'(bus.out_data), 3);
    drain();

    // drop counter saturation
    for (int i = 0; i < 16 + 260; i++) drive(1'b1, i % 8, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    check("sat_drop", int'(drop_cnt), 255);
    check("sat_ovf", int'(overflow), 1);

    // clear coinciding with a drop
    drive(1'b1, 1, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0);
    check("clr_ovf", int'(overflow), 0);
    check("clr_drop", int'(drop_cnt), 0);
    drain();

    // random traffic
    for (int c = 0; c < 400; c++)
      drive(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 19) == 0));
    drain();
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voc_out_fifo.md
Name: voc_out_fifo

Overview:
- Downstream stage of the vocoder playback unit.
- Accepts the WIDTH-bit replay samples while the unit's status is high, which is presented to this block as in_valid.
- Buffers the samples in a first-word-fall-through FIFO and hands them to the sink over a valid/ready handshake.
- Tags burst-start and frame-end boundaries on the output and records sample drops caused by sink backpressure.

Parameters:
- WIDTH, 3: sample width in bits; matches the playback unit's data width.
- DEPTH, 16: FIFO entries; must be a power of 2 and at least 2.
- FRAME, 8: samples per output frame; matches the playback unit's SIZE.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present this cycle; driven by the playback unit's status.
- in_data  in  WIDTH  sample from the playback unit's data_out.
- out_ready  in  1  sink accepts out_data this cycle.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_data  out  WIDTH  head-of-FIFO sample.
- out_first  out  1  head sample is the first sample of an input burst.
- out_last  out  1  head sample is the FRAME-th output since reset or the last wrap.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one sample dropped.
- drop_cnt  out  DROP_W  number of dropped samples, saturating.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read and write pointers, level, frame counter, overflow, drop_cnt and prev_valid all go to 0.
  - Outputs: out_valid=0, out_first=0, out_last=0, level=0, overflow=0, drop_cnt=0.
  - Memory contents are don't-care.
  - A reset asserted mid-burst discards all stored data. The first accepted sample after release is tagged first=1.
- Push:
  - push = in_valid && (!full || pop).
  - Each entry stores {first_tag, in_data}, where first_tag = in_valid && !prev_valid.
  - prev_valid registers in_valid every cycle.
- Pop: pop = out_valid && out_ready.
- Latency: a sample pushed into an empty FIFO appears on out_valid/out_data on the next cycle. There is no combinational path from in_* to out_*.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- full = (level==DEPTH); empty = (level==0); out_valid = !empty.
- Full with simultaneous pop: the push is accepted, level stays DEPTH, and there is no drop.
- Full without pop while in_valid=1: the sample is dropped.
  - overflow is set to 1.
  - drop_cnt increments, saturating at 2^DROP_W-1.
  - No pointer changes.
  - The next accepted sample keeps its own first_tag. A drop does not re-tag.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- out_first comes from the stored tag of the head entry. It is 0 when empty.
- Frame counter:
  - Counts pops, range 0..FRAME-1.
  - out_last = out_valid && (frame_cnt==FRAME-1).
  - A pop with out_last high wraps the counter to 0.
  - Not affected by drops or pushes.
- clr_ovf:
  - Clears overflow and drop_cnt on the next edge.
  - If a drop occurs in the same cycle, the clear wins: both read 0 next cycle.
- out_data is held stable while out_valid=1 and out_ready=0.

Decomposition:
- Package voc_pkg holds:
  - VOC_WIDTH=3 and VOC_SIZE=8 defaults, shared with the vocoder units.
  - A localparam for the stored entry width (WIDTH+1).
- Sub-module voc_fifo_mem: a DEPTH x (WIDTH+1) register array with one synchronous write port and an asynchronous read at rd_ptr.
- The top level keeps pointers, level, tagging, the frame counter and overflow logic.

Test Plan:
- Reset and basic flow: hold rst_n=0 for 3 cycles, then release with out_ready=1 and push 5,2,7 on consecutive cycles.
  - Required: out_data=5,2,7 on the following cycles.
  - Required: out_first=1 only on sample 5.
  - Required: level never exceeds 1.
- Fill and overflow: out_ready=0, in_valid=1 for 20 cycles, data=i mod 8.
  - Required: level=16 and full.
  - Required: overflow=1 and drop_cnt=4.
  - Required: after out_ready=1, out_data reads 0..7,0..7 in order.
- Full with simultaneous push and pop: fill to 16, then out_ready=1 and in_valid=1 for 4 cycles.
  - Required: level stays 16 and drop_cnt is unchanged.
  - Required: the 4 new samples come out last, in order.
- Frame tagging: 2 input bursts of 8 samples each (in_valid low for 2 cycles between), with out_ready=1.
  - Required: out_last on pops 8 and 16.
  - Required: out_first on pops 1 and 9.
- Backpressure hold: out_ready toggles 0/1 every cycle.
  - Required: out_data is stable whenever out_ready=0.
  - Required: no sample is lost or duplicated (scoreboard match).
- Reset mid-burst and clr_ovf:
  - Assert rst_n=0 for 1 cycle with level=6. Required: level=0 and out_valid=0 immediately (asynchronous). The next pushed sample has out_first=1.
  - Separately, pulse clr_ovf in the same cycle as a drop. Required: overflow=0 and drop_cnt=0 next cycle.
